serial_pattern_gen: RTL and testbench
=====================================

Name: serial_pattern_gen

Overview:
- Serial bit-pattern transmitter: accepts a parallel pattern plus length/repeat/gap settings over a valid/ready request port, and drives it onto a one-bit serial line, MSB-first, one bit per clock.
- Produces the serial streams consumed by the team's serial sequence detectors, in bench loopback and in the datapath.
- Supports repeated transmission with programmable idle gaps, mid-frame abort, and a completion pulse.

Parameters:
- WIDTH, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(WIDTH+1), width of the length field.
- REP_W, 4, width of the repeat-count field.
- GAP_W, 4, width of the inter-repeat gap field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- pat_in  in  WIDTH  pattern; bits [len-1:0] are sent, bit len-1 first.
- pat_len  in  LEN_W  bits per repetition, 1..WIDTH; 0 or >WIDTH is treated as WIDTH.
- reps  in  REP_W  number of transmissions; 0 is treated as 1.
- gap  in  GAP_W  idle cycles between repetitions; 0 means back-to-back.
- abort  in  1  cancel the current frame.
- ser_out  out  1  serial data.
- ser_valid  out  1  ser_out carries a pattern bit this cycle.
- busy  out  1  frame in progress (SHIFT or GAP).
- done  out  1  one-cycle pulse marking the final bit of a completed frame.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- All outputs except req_ready are registered.
- Reset values: state=IDLE, ser_out=0, ser_valid=0, busy=0, done=0; internal counters and pattern register cleared.
- Handshake:
  - req_ready = (state==IDLE) & ~abort.
  - A request is accepted on the edge where req_valid & req_ready; pat_in, pat_len, reps and gap are captured then.
  - Inputs are ignored at all other times. req_valid may stay high while busy; it is accepted on the first ready cycle.
- State IDLE: ser_valid=0, ser_out=0, busy=0. On accept, go to SHIFT.
- State SHIFT:
  - Latency: the first bit appears in the cycle after accept.
  - ser_valid=1 and busy=1.
  - bit_idx counts len-1 down to 0; ser_out = pattern[bit_idx].
  - At bit_idx=0:
    - If this was the last repetition: done=1 this cycle, and the next state is IDLE.
    - Else if gap>0: go to GAP.
    - Else: reload bit_idx=len-1 and stay in SHIFT, so the next repetition follows with no bubble.
- State GAP: ser_valid=0, ser_out=0, busy=1. Count gap cycles, then return to SHIFT with bit_idx=len-1.
- Frame duration: reps_eff*len_eff + (reps_eff-1)*gap cycles. The minimum spacing between frames is one IDLE cycle.
- Abort:
  - Abort while in SHIFT or GAP: next state is IDLE; ser_valid=0 and busy=0 from the next cycle; no done pulse.
  - The bit driven in the abort cycle itself is still valid.
  - Abort in IDLE blocks acceptance that cycle.
- Abort on the final bit: done is still asserted in that cycle, since the frame is complete; the state goes to IDLE either way.
- Reset mid-frame: the frame is discarded and all outputs take their reset values on the next edge.
- len=1: each repetition is a single bit; done coincides with the only bit when reps=1.
- Counters saturate at no point. Widths are fixed by LEN_W, REP_W and GAP_W, and no wrap-around is reachable.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - a function normalising len (0 or >WIDTH -> WIDTH);
  - a function normalising reps (0 -> 1).
- Sub-module: pattern_shift_reg.
  - WIDTH-bit loadable register with an indexed bit select.
  - Ports: load, data, idx, bit_out.
  - The control FSM and the counters stay in serial_pattern_gen.

Test Plan:
- Single frame: pat_in=8'b0000_0101, pat_len=3, reps=1, gap=0; accept at cycle 0 -> ser_out 1,0,1 with ser_valid=1 in cycles 1-3; done=1 in cycle 3 only; req_ready=1 in cycle 4.
- Repeat with gap: same pattern, reps=2, gap=2 -> cycles 1-3 carry 1,0,1; cycles 4-5 have ser_valid=0, ser_out=0; cycles 6-8 carry 1,0,1; done=1 in cycle 8; busy=1 in cycles 1-8.
- Defaults: pat_in=8'hA5, pat_len=0, reps=0 -> 8 bits 1,0,1,0,0,1,0,1 in cycles 1-8; done in cycle 8.
- Back-to-back: reps=3, gap=0, pat_len=2, pat_in=2'b10 -> 1,0,1,0,1,0 contiguous in cycles 1-6; req_valid held high is accepted again at cycle 7, not earlier.
- Abort: abort=1 in cycle 2 of the 8'hA5 frame -> the cycle-2 bit is valid; ser_valid=0 and busy=0 from cycle 3; done is never asserted; req_ready=1 in cycle 3.
- Reset mid-frame: rst=1 in cycle 4 of a gap frame -> from cycle 5 all outputs are 0 and req_ready=1; a new request is then accepted normally.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and field-normalisation helpers for the serial pattern generator.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  function automatic int unsigned norm_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

  function automatic int unsigned norm_reps(input int unsigned reps);
    return (reps == 0) ? 1 : reps;
  endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Loadable pattern register with an indexed bit select.
module pattern_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [IDX_W-1:0] idx,
  output logic             bit_out
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (load) r_q <= data;
  end

  // Selects from the incoming data while loading so the caller sees the
  // bit that will be held after this edge.
  assign bit_out = load ? data[idx] : r_q[idx];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: MSB-first, repeat count, inter-repeat gaps, abort.
module serial_pattern_gen
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = $clog2(WIDTH + 1),
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [IDX_W-1:0] r_len_m1, w_len_m1_nxt, w_len_m1_in;
  logic [REP_W-1:0] r_reps, w_reps_nxt, w_reps_in;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic             w_accept;
  logic             w_bit_nxt;

  assign req_ready   = (r_state == IDLE) & ~abort;
  assign w_accept    = req_valid & req_ready;
  assign w_len_m1_in = IDX_W'(norm_len(32'(pat_len), WIDTH) - 1);
  assign w_reps_in   = REP_W'(norm_reps(32'(reps)));

  pattern_shift_reg #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_pat (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .data   (pat_in),
    .idx    (w_idx_nxt),
    .bit_out(w_bit_nxt)
  );

  // r_reps counts repetitions remaining including the one being sent.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_len_m1_nxt  = r_len_m1;
    w_reps_nxt    = r_reps;
    w_gap_nxt     = r_gap;
    w_gap_cnt_nxt = r_gap_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = SHIFT;
          w_idx_nxt    = w_len_m1_in;
          w_len_m1_nxt = w_len_m1_in;
          w_reps_nxt   = w_reps_in;
          w_gap_nxt    = gap;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_idx == '0) begin
          if (r_reps == REP_W'(1)) begin
            w_state_nxt = IDLE;
          end else begin
            w_reps_nxt = r_reps - REP_W'(1);
            w_idx_nxt  = r_len_m1;
            if (r_gap != '0) begin
              w_state_nxt   = GAP;
              w_gap_cnt_nxt = r_gap;
            end
          end
        end else begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end
      end
      GAP: begin
        if (abort)                        w_state_nxt = IDLE;
        else if (r_gap_cnt == GAP_W'(1))  w_state_nxt = SHIFT;
        else                              w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_len_m1  <= '0;
      r_reps    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_len_m1  <= w_len_m1_nxt;
      r_reps    <= w_reps_nxt;
      r_gap     <= w_gap_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      ser_valid <= (w_state_nxt == SHIFT);
      ser_out   <= (w_state_nxt == SHIFT) & w_bit_nxt;
      busy      <= (w_state_nxt != IDLE);
      done      <= (w_state_nxt == SHIFT) && (w_idx_nxt == '0) && (w_reps_nxt == REP_W'(1));
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Randomised bench for serial_pattern_gen against a per-cycle expected-stream queue model.
module tb_serial_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] pat_in;
  logic [3:0] pat_len;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       abort;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  serial_pattern_gen #(
    .WIDTH(8),
    .LEN_W(4),
    .REP_W(4),
    .GAP_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .pat_in   (pat_in),
    .pat_len  (pat_len),
    .reps     (reps),
    .gap      (gap),
    .abort    (abort),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic v;
    logic b;
    logic bz;
    logic dn;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole frame expanded into one entry per output cycle.
  task automatic build(input logic [7:0] pat, input logic [3:0] len,
                       input logic [3:0] rp, input logic [3:0] gp);
    int unsigned le, re, ge;
    logic [7:0]  sh;
    le = 32'(len);
    if (le == 0 || le > 8) le = 8;
    re = 32'(rp);
    if (re == 0) re = 1;
    ge = 32'(gp);
    for (int unsigned r = 0; r < re; r++) begin
      sh = pat << (8 - le);
      for (int unsigned k = 0; k < le; k++) begin
        q.push_back('{v: 1'b1, b: sh[7], bz: 1'b1, dn: (r == re - 1 && k == le - 1)});
        sh = sh << 1;
      end
      if (r != re - 1)
        for (int unsigned g = 0; g < ge; g++) q.push_back('{v: 1'b0, b: 1'b0, bz: 1'b1, dn: 1'b0});
    end
  endtask

  task automatic cyc(input logic rv, input logic [7:0] pat, input logic [3:0] len,
                     input logic [3:0] rp, input logic [3:0] gp, input logic ab, input logic rs);
    @(negedge clk);
    req_valid = rv;
    pat_in    = pat;
    pat_len   = len;
    reps      = rp;
    gap       = gp;
    abort     = ab;
    rst       = rs;
    #1;
    check("ser_valid", ser_valid, cur.v);
    check("ser_out",   ser_out,   cur.b);
    check("busy",      busy,      cur.bz);
    check("done",      done,      cur.dn);
    check("req_ready", req_ready, !cur.bz && !ab);
    @(posedge clk);
    if (rs) begin
      q.delete();
    end else begin
      if (cur.bz && ab) q.delete();
      if (!cur.bz && !ab && rv) build(pat, len, rp, gp);
    end
    cur = (!rs && q.size() > 0) ? q.pop_front() : '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; pat_in = '0; pat_len = '0;
    reps = '0; gap = '0; abort = 1'b0;
    @(posedge clk);
    cur = '0;
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);

    // single frame, repeat with gap, defaults
    cyc(1'b1, 8'h05, 4'd3, 4'd1, 4'd0, 1'b0, 1'b0); idle(5);
    cyc(1'b1, 8'h05, 4'd3, 4'd2, 4'd2, 1'b0, 1'b0); idle(10);
    cyc(1'b1, 8'hA5, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0); idle(10);
    // back-to-back with request held high
    repeat (9) cyc(1'b1, 8'h02, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0);
    idle(8);
    // abort in cycle 2
    cyc(1'b1, 8'hA5, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(5);
    // abort on the final bit still gives done
    cyc(1'b1, 8'h06, 4'd3, 4'd1, 4'd0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(3);
    // abort in IDLE blocks acceptance
    cyc(1'b1, 8'hFF, 4'd4, 4'd1, 4'd0, 1'b1, 1'b0); idle(3);
    // reset mid-frame in cycle 4 of a gap frame, then a normal request
    cyc(1'b1, 8'h05, 4'd3, 4'd2, 4'd2, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    idle(2);
    cyc(1'b1, 8'h3C, 4'd6, 4'd2, 4'd1, 1'b0, 1'b0); idle(16);
    // len=1 and len>WIDTH
    cyc(1'b1, 8'h01, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0); idle(3);
    cyc(1'b1, 8'h01, 4'd1, 4'd3, 4'd1, 1'b0, 1'b0); idle(7);
    cyc(1'b1, 8'h96, 4'd12, 4'd1, 4'd0, 1'b0, 1'b0); idle(10);

    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 1)),
          8'($urandom),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2)),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
